mips_fetch_unit: RTL and testbench

Upstream instruction-fetch stage for the single-cycle MIPS datapath. It holds the PC and fetches instructions through a req/valid handshake to instruction memory. It presents the decoded instruction fields, including the 6-bit opcode consumed by the main control decoder. It then computes the next PC from the Branch/Ne/zero outcome of the executing instruction.

---
 rtl/mips_fetch_unit.sv | 110 +++++++++++
 tb/tb_mips_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/valid handshake,
// presents decoded instruction fields and computes the branch-aware next PC.
module mips_fetch_unit #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                branch,
  input  logic                ne,
  input  logic                alu_zero,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [5:0]          funct,
  output logic [15:0]         imm16,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [31:0]         issue_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_RST = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         count_q, count_d;

  logic                taken;
  logic [PC_WIDTH-1:0] branch_off;
  logic [PC_WIDTH-1:0] next_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // A bitwise AND keeps an unknown ne from leaking into next_pc when branch=0.
  assign taken      = branch & (alu_zero ^ ne);
  assign branch_off = {{(PC_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign pc_plus4   = pc_q + PC_WIDTH'(4);
  assign next_pc    = taken ? (pc_plus4 + branch_off) : pc_plus4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign imm16       = instr_q[15:0];
  assign issue_count = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a transaction-level PC/instruction model.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, b_imem_req;
  logic [31:0] imem_addr, b_imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid, stall, branch, ne, alu_zero;
  logic        instr_valid, b_instr_valid;
  logic [31:0] instr, b_instr;
  logic [5:0]  opcode, funct, b_opcode, b_funct;
  logic [4:0]  rs, rt, rd, b_rs, b_rt, b_rd;
  logic [15:0] imm16, b_imm16;
  logic [31:0] pc, pc_plus4, issue_count, b_pc, b_pc_plus4, b_issue_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  localparam logic [31:0] B_BASE = 32'h0000_0104;

  always #5 clk = ~clk;

  mips_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .branch(branch), .ne(ne), .alu_zero(alu_zero), .instr_valid(instr_valid),
    .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4), .issue_count(issue_count)
  );

  // Unaligned reset vector: low two bits must be dropped.
  mips_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0107)) dut_b (
    .clk(clk), .reset(reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .branch(branch), .ne(ne), .alu_zero(alu_zero), .instr_valid(b_instr_valid),
    .instr(b_instr), .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd), .funct(b_funct),
    .imm16(b_imm16), .pc(b_pc), .pc_plus4(b_pc_plus4), .issue_count(b_issue_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
  endtask

  // One full instruction: fetch (with nwait idle memory cycles), issue (with
  // nstall stalled cycles), then retire with the given branch inputs.
  task automatic fetch_one(input int unsigned nwait, input logic [31:0] rdata,
                           input int unsigned nstall, input logic br,
                           input logic ne_v, input logic z_v);
    logic [31:0] next;
    int          off;
    wait_req();
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_iv", 32'(instr_valid), 32'd0);
    for (int unsigned w = 0; w < nwait; w++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      stall      = 1'($urandom);
      @(negedge clk);
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, exp_pc);
    end
    imem_valid = 1'b1;
    imem_rdata = rdata;
    stall      = 1'($urandom);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    check("issue_iv", 32'(instr_valid), 32'd1);
    check("issue_req", 32'(imem_req), 32'd0);
    check("instr", instr, rdata);
    check("opcode", 32'(opcode), 32'(rdata[31:26]));
    check("rs", 32'(rs), 32'(rdata[25:21]));
    check("rt", 32'(rt), 32'(rdata[20:16]));
    check("rd", 32'(rd), 32'(rdata[15:11]));
    check("funct", 32'(funct), 32'(rdata[5:0]));
    check("imm16", 32'(imm16), 32'(rdata[15:0]));
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int unsigned s = 0; s < nstall; s++) begin
      stall      = 1'b1;
      imem_valid = 1'($urandom);
      branch     = 1'($urandom);
      ne         = 1'($urandom);
      alu_zero   = 1'($urandom);
      @(negedge clk);
      check("stall_iv", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pc", pc, exp_pc);
      check("stall_instr", instr, rdata);
      check("stall_cnt", issue_count, exp_count);
    end
    stall      = 1'b0;
    imem_valid = 1'($urandom);
    branch     = br;
    ne         = ne_v;
    alu_zero   = z_v;
    @(negedge clk);
    imem_valid = 1'b0;
    branch     = 1'b0;
    off        = int'($signed(rdata[15:0])) * 4;
    next       = exp_pc + 32'd4;
    if (br && (z_v != ne_v)) next = next + 32'(off);
    exp_pc    = next;
    exp_count = exp_count + 32'd1;
    check("retire_iv", 32'(instr_valid), 32'd0);
    check("retire_req", 32'(imem_req), 32'd1);
    check("retire_addr", imem_addr, exp_pc);
    check("retire_cnt", issue_count, exp_count);
    check("b_pc", b_pc, exp_pc + B_BASE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch = 1'b0; ne = 1'b0; alu_zero = 1'b0;
    exp_pc = '0; exp_count = '0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_iv", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_cnt", issue_count, 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_b_pc", b_pc, B_BASE);
    reset = 1'b0;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);

    // lw zero-wait, then two more sequential instructions
    fetch_one(0, 32'h8C22_0004, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(0, 32'h0000_0020, 0, 1'b0, 1'b1, 1'b0);
    fetch_one(0, 32'h2002_0005, 0, 1'b0, 1'b0, 1'b1);
    check("seq_cnt3", issue_count, 32'd3);
    check("seq_addr", imem_addr, 32'd12);
    fetch_one(0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0);
    // beq taken from 0x10 with imm -3
    fetch_one(0, 32'h1000_FFFD, 0, 1'b1, 1'b0, 1'b1);
    check("beq_taken", imem_addr, 32'h08);
    fetch_one(0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(0, 32'h1400_FFFD, 0, 1'b1, 1'b1, 1'b1);
    check("bne_nt", imem_addr, 32'h14);
    fetch_one(0, 32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1);
    check("back_to_10", imem_addr, 32'h10);
    fetch_one(0, 32'h1400_FFFD, 0, 1'b1, 1'b1, 1'b0);
    check("bne_taken", imem_addr, 32'h08);
    // long stall and delayed memory response
    fetch_one(4, 32'h0000_0020, 5, 1'b0, 1'b0, 1'b0);

    // reset in FETCH with a simultaneous response
    wait_req();
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstf_instr", instr, 32'd0);
    check("rstf_req", 32'(imem_req), 32'd0);
    check("rstf_iv", 32'(instr_valid), 32'd0);
    check("rstf_cnt", issue_count, 32'd0);
    exp_pc = '0; exp_count = '0;
    // response presented in IDLE must be ignored
    @(negedge clk);
    imem_valid = 1'b0;
    check("idle_ign_req", 32'(imem_req), 32'd1);
    check("idle_ign_iv", 32'(instr_valid), 32'd0);
    check("idle_ign_instr", instr, 32'd0);
    check("idle_ign_addr", imem_addr, 32'd0);

    // wrap: branch back from 0 to 0xFFFFFFFC, then fall through to 0
    fetch_one(1, 32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1);
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    fetch_one(0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_post", imem_addr, 32'h0000_0000);

    for (int i = 0; i < 60; i++) begin
      fetch_one($urandom_range(0, 3), $urandom, $urandom_range(0, 2),
                1'($urandom), 1'($urandom), 1'($urandom));
      check("addr_align", 32'(imem_addr[1:0]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
